// File: rtl/panxi_ifu_fetch.sv
// -----------------------------------------------------------------------------
// panxi_ifu_fetch
// Instruction-fetch unit for the PANXI RV32 core. Owns the fetch PC, issues
// pipelined requests to the I-cache, buffers returned instructions in a small
// in-order fetch queue and presents them to IF/ID. A redirect (flush) empties
// the queue and marks every in-flight response as stale so it is discarded.
//
// Optional feature macro: PANXI_IF_MISALIGN_CHK_EN
//   When defined, a redirect to a non-word-aligned target halts fetch and
//   queues a single misaligned-target entry (id_err = 2'b10) instead.
//   When undefined, the low two bits of flush_pc are ignored.
// -----------------------------------------------------------------------------
module panxi_ifu_fetch #(
   parameter int                  PANXI_DW = 32,
   parameter int                  QDEPTH   = 4,
   parameter int                  MAX_OUT  = 2,
   parameter logic [PANXI_DW-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ic_req_vld,
   output logic [PANXI_DW-1:0] ic_req_addr,
   input  logic                ic_req_rdy,
   input  logic                ic_rsp_vld,
   input  logic [PANXI_DW-1:0] ic_rsp_data,
   input  logic                ic_rsp_err,
   output logic                id_vld,
   output logic [PANXI_DW-1:0] id_pc,
   output logic [PANXI_DW-1:0] id_inst,
   output logic [1:0]          id_err,
   input  logic                id_rdy,
   input  logic                flush,
   input  logic [PANXI_DW-1:0] flush_pc,
   output logic                fq_empty,
   output logic                fq_full
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);

   localparam logic [1:0]          ERR_NONE  = 2'b00;
   localparam logic [1:0]          ERR_FAULT = 2'b01;
   localparam logic [PANXI_DW-1:0] PC_STEP   = PANXI_DW'(4);
`ifdef PANXI_IF_MISALIGN_CHK_EN
   localparam logic [1:0]          ERR_MISALIGN = 2'b10;
`else
   localparam logic [PANXI_DW-1:0] ALIGN_MASK   = ~PANXI_DW'(3);
`endif

   // Architectural state
   logic [PANXI_DW-1:0] pc;        // next fetch address
   logic [PANXI_DW-1:0] rsp_pc;    // PC belonging to the next kept response
   logic                run;       // low for the first cycle out of reset
   logic [CW-1:0]       cnt;       // queue occupancy
   logic [OW-1:0]       out;       // outstanding I-cache requests
   logic [OW-1:0]       drop;      // stale responses still to discard
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
`ifdef PANXI_IF_MISALIGN_CHK_EN
   logic                halt;      // fetch stopped after a misaligned redirect
   logic                mis_pend;  // misaligned entry to push this cycle
`endif

   // Fetch-queue storage
   logic [PANXI_DW-1:0] q_pc   [QDEPTH];
   logic [PANXI_DW-1:0] q_inst [QDEPTH];
   logic [1:0]          q_err  [QDEPTH];

   // Per-cycle handshakes and derived values
   logic                req_fire;
   logic                rsp_fire;
   logic                keep;
   logic                push;
   logic                pop;
   logic [OW-1:0]       out_next;
   logic [CW:0]         live;
   logic [PANXI_DW-1:0] tgt_pc;
   logic [PANXI_DW-1:0] push_pc;
   logic [PANXI_DW-1:0] push_inst;
   logic [1:0]          push_err;

   // Slots already claimed: queued entries plus live (non-stale) requests.
   // out never falls below drop, so the subtraction cannot wrap.
   assign live = (CW+1)'(cnt) + (CW+1)'(out) - (CW+1)'(drop);

   // Request valid uses registered state only, so it holds steady until accepted.
   assign ic_req_vld = run
`ifdef PANXI_IF_MISALIGN_CHK_EN
                       && !halt
`endif
                       && (out < OW'(MAX_OUT))
                       && (live < (CW+1)'(QDEPTH));
   assign ic_req_addr = pc;

   assign req_fire = ic_req_vld && ic_req_rdy;
   assign rsp_fire = ic_rsp_vld;
   assign keep     = rsp_fire && (drop == '0) && !flush;
   assign pop      = id_vld && id_rdy && !flush;
   assign out_next = out + OW'(req_fire) - OW'(rsp_fire);

`ifdef PANXI_IF_MISALIGN_CHK_EN
   assign tgt_pc = flush_pc;
`else
   assign tgt_pc = flush_pc & ALIGN_MASK;
`endif

   assign id_vld   = (cnt != '0);
   assign fq_empty = (cnt == '0);
   assign fq_full  = (cnt == CW'(QDEPTH));

   // Head outputs read as zero whenever the queue is empty.
   assign id_pc   = id_vld ? q_pc[rd_ptr]   : '0;
   assign id_inst = id_vld ? q_inst[rd_ptr] : '0;
   assign id_err  = id_vld ? q_err[rd_ptr]  : ERR_NONE;

   // Select what is written into the queue this cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      push      = keep;
      push_pc   = rsp_pc;
      push_inst = ic_rsp_data;
      push_err  = ic_rsp_err ? ERR_FAULT : ERR_NONE;
`ifdef PANXI_IF_MISALIGN_CHK_EN
      if (mis_pend && !flush) begin
         push      = 1'b1;
         push_pc   = pc;
         push_inst = '0;
         push_err  = ERR_MISALIGN;
      end
`endif
   end

   // Queue storage write; valid-ness is tracked by cnt and the pointers.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; the head outputs are masked while empty.
      if (push) begin
         q_pc[wr_ptr]   <= push_pc;
         q_inst[wr_ptr] <= push_inst;
         q_err[wr_ptr]  <= push_err;
      end
   end

   // PC, occupancy, outstanding/stale counters; flush overrides everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         run      <= 1'b0;
         cnt      <= '0;
         out      <= '0;
         drop     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
`ifdef PANXI_IF_MISALIGN_CHK_EN
         halt     <= 1'b0;
         mis_pend <= 1'b0;
`endif
      end else begin
         run <= 1'b1;
         out <= out_next;
         if (flush) begin
            pc     <= tgt_pc;
            rsp_pc <= tgt_pc;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= out_next;   // everything still in flight is now stale
`ifdef PANXI_IF_MISALIGN_CHK_EN
            halt     <= (flush_pc[1:0] != 2'b00);
            mis_pend <= (flush_pc[1:0] != 2'b00);
`endif
         end else begin
            if (req_fire) pc <= pc + PC_STEP;
            if (keep) rsp_pc <= rsp_pc + PC_STEP;
            if (rsp_fire && (drop != '0)) drop <= drop - OW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
`ifdef PANXI_IF_MISALIGN_CHK_EN
            mis_pend <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_panxi_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_panxi_ifu_fetch
// Directed bench for panxi_ifu_fetch (QDEPTH=4, MAX_OUT=2, RESET_PC=0x100).
// A small in-order I-cache responder returns ~addr as the instruction after a
// programmable latency and can flag one address as an access fault.
// -----------------------------------------------------------------------------
module tb_panxi_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ic_req_vld;
   logic [31:0] ic_req_addr;
   logic        ic_req_rdy;
   logic        ic_rsp_vld;
   logic [31:0] ic_rsp_data;
   logic        ic_rsp_err;
   logic        id_vld;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [1:0]  id_err;
   logic        id_rdy;
   logic        flush;
   logic [31:0] flush_pc;
   logic        fq_empty;
   logic        fq_full;

   int          checks   = 0;
   int          failures = 0;

   // I-cache responder state
   int          lat      = 1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   int          cyc = 0;

   panxi_ifu_fetch #(
      .PANXI_DW (32),
      .QDEPTH   (4),
      .MAX_OUT  (2),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ic_req_vld  (ic_req_vld),
      .ic_req_addr (ic_req_addr),
      .ic_req_rdy  (ic_req_rdy),
      .ic_rsp_vld  (ic_rsp_vld),
      .ic_rsp_data (ic_rsp_data),
      .ic_rsp_err  (ic_rsp_err),
      .id_vld      (id_vld),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_err      (id_err),
      .id_rdy      (id_rdy),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .fq_empty    (fq_empty),
      .fq_full     (fq_full)
   );

   always #5 clk = ~clk;

   // In-order I-cache: a request accepted in cycle N answers in cycle N+lat.
   always @(posedge clk) begin
      logic [31:0] a_tmp;
      int          d_tmp;
      if (ic_rsp_vld && pend_addr.size() > 0) begin
         a_tmp = pend_addr.pop_front();
         d_tmp = pend_due.pop_front();
      end
      cyc++;
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
      end else if (ic_req_vld === 1'b1 && ic_req_rdy) begin
         pend_addr.push_back(ic_req_addr);
         pend_due.push_back(cyc + lat - 1);
      end
      #1;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         ic_rsp_vld  = 1'b1;
         ic_rsp_data = ~pend_addr[0];
         ic_rsp_err  = (pend_addr[0] == err_addr);
      end else begin
         ic_rsp_vld  = 1'b0;
         ic_rsp_data = '0;
         ic_rsp_err  = 1'b0;
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two rising edges; leaves rst_n low.
   task automatic hold_reset();
      step();
      rst_n      = 1'b0;
      flush      = 1'b0;
      flush_pc   = '0;
      id_rdy     = 1'b0;
      ic_req_rdy = 1'b1;
      err_addr   = 32'hFFFF_FFFF;
      step();
      step();
   endtask

   task automatic test_reset();
      hold_reset();
      lat = 1;
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b0) begin failures++; $display("FAIL rst_req_vld got=%h exp=0", ic_req_vld); end
      checks++; if (ic_req_addr !== 32'h100) begin failures++; $display("FAIL rst_req_addr got=%h exp=00000100", ic_req_addr); end
      checks++; if (id_vld !== 1'b0) begin failures++; $display("FAIL rst_id_vld got=%h exp=0", id_vld); end
      checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
      checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rst_id_inst got=%h exp=0", id_inst); end
      checks++; if (id_err !== 2'b00) begin failures++; $display("FAIL rst_id_err got=%b exp=00", id_err); end
      checks++; if (fq_empty !== 1'b1) begin failures++; $display("FAIL rst_fq_empty got=%h exp=1", fq_empty); end
      checks++; if (fq_full !== 1'b0) begin failures++; $display("FAIL rst_fq_full got=%h exp=0", fq_full); end
      rst_n = 1'b1;
   endtask

   // Request valid and address must hold while the I-cache stalls.
   task automatic test_req_hold();
      hold_reset();
      ic_req_rdy = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h100) begin
            failures++; $display("FAIL hold_req c=%0d got vld=%h addr=%h exp vld=1 addr=00000100", c, ic_req_vld, ic_req_addr);
         end
      end
      step();
      ic_req_rdy = 1'b1;
      step();
      @(negedge clk);
      checks++; if (ic_req_addr !== 32'h104) begin failures++; $display("FAIL hold_next_addr got=%h exp=00000104", ic_req_addr); end
   endtask

   // Back-to-back stream from RESET_PC, one instruction per cycle.
   task automatic test_stream();
      int          first_req;
      int          first_id;
      int          k;
      logic [31:0] exp_pc;
      hold_reset();
      lat    = 1;
      id_rdy = 1'b1;
      rst_n  = 1'b1;
      first_req = -1;
      first_id  = -1;
      k = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         @(negedge clk);
         if (first_req < 0 && ic_req_vld === 1'b1) first_req = c;
         if (id_vld === 1'b1) begin
            if (first_id < 0) first_id = c;
            if (k < 8) begin
               exp_pc = 32'h100 + 32'(4 * k);
               checks++; if (id_pc !== exp_pc || id_inst !== ~exp_pc || id_err !== 2'b00) begin
                  failures++; $display("FAIL stream_entry k=%0d got pc=%h inst=%h err=%b exp pc=%h inst=%h err=00", k, id_pc, id_inst, id_err, exp_pc, ~exp_pc);
               end
               k++;
            end
         end else if (first_id >= 0 && k < 8) begin
            checks++; failures++;
            $display("FAIL stream_gap c=%0d got id_vld=%h exp=1", c, id_vld);
         end
      end
      checks++; if (first_req != 0 || first_id != 2) begin
         failures++; $display("FAIL stream_latency got req_cycle=%0d id_cycle=%0d exp req_cycle=0 id_cycle=2", first_req, first_id);
      end
      checks++; if (k != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", k); end
   endtask

   // id_rdy held low: the queue fills, fetch stops, nothing is lost.
   task automatic test_backpressure();
      logic [31:0] exp_pc;
      hold_reset();
      lat    = 1;
      id_rdy = 1'b0;
      rst_n  = 1'b1;
      for (int c = 0; c < 10; c++) step();
      @(negedge clk);
      checks++; if (fq_full !== 1'b1) begin failures++; $display("FAIL bp_full got=%h exp=1", fq_full); end
      checks++; if (fq_empty !== 1'b0) begin failures++; $display("FAIL bp_empty got=%h exp=0", fq_empty); end
      checks++; if (ic_req_vld !== 1'b0) begin failures++; $display("FAIL bp_req_vld got=%h exp=0", ic_req_vld); end
      checks++; if (id_vld !== 1'b1 || id_pc !== 32'h100) begin
         failures++; $display("FAIL bp_head got vld=%h pc=%h exp vld=1 pc=00000100", id_vld, id_pc);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         id_rdy = 1'b1;
         @(negedge clk);
         exp_pc = 32'h100 + 32'(4 * k);
         checks++; if (id_vld !== 1'b1 || id_pc !== exp_pc || id_inst !== ~exp_pc) begin
            failures++; $display("FAIL bp_drain k=%0d got vld=%h pc=%h inst=%h exp vld=1 pc=%h inst=%h", k, id_vld, id_pc, id_inst, exp_pc, ~exp_pc);
         end
      end
   endtask

   // Flush to 0x2000 while two requests are outstanding (latency 3).
   task automatic test_flush_inflight();
      int n;
      hold_reset();
      lat    = 3;
      id_rdy = 1'b1;
      rst_n  = 1'b1;
      step();
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h100) begin
         failures++; $display("FAIL fi_first_req got vld=%h addr=%h exp vld=1 addr=00000100", ic_req_vld, ic_req_addr);
      end
      step();
      step();
      flush    = 1'b1;
      flush_pc = 32'h2000;
      step();
      flush    = 1'b0;
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b0 || id_vld !== 1'b0) begin
         failures++; $display("FAIL fi_after_flush got req_vld=%h id_vld=%h exp 0 0", ic_req_vld, id_vld);
      end
      step();
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h2000) begin
         failures++; $display("FAIL fi_redirect_req got vld=%h addr=%h exp vld=1 addr=00002000", ic_req_vld, ic_req_addr);
      end
      n = 0;
      while (id_vld !== 1'b1 && n < 10) begin
         step();
         @(negedge clk);
         n++;
      end
      checks++; if (n != 4 || id_pc !== 32'h2000 || id_inst !== ~32'h2000) begin
         failures++; $display("FAIL fi_first_entry got wait=%0d pc=%h inst=%h exp wait=4 pc=00002000 inst=%h", n, id_pc, id_inst, ~32'h2000);
      end
      step();
      @(negedge clk);
      checks++; if (id_vld !== 1'b1 || id_pc !== 32'h2004 || id_inst !== ~32'h2004) begin
         failures++; $display("FAIL fi_second_entry got vld=%h pc=%h inst=%h exp vld=1 pc=00002004 inst=%h", id_vld, id_pc, id_inst, ~32'h2004);
      end
   endtask

   // Flush in a cycle that also carries a response and a pop.
   task automatic test_flush_rsp_pop();
      int n;
      hold_reset();
      lat    = 1;
      id_rdy = 1'b1;
      rst_n  = 1'b1;
      for (int c = 0; c < 6; c++) step();
      step();
      flush    = 1'b1;
      flush_pc = 32'h4000;
      @(negedge clk);
      checks++; if (id_vld !== 1'b1) begin failures++; $display("FAIL frp_pre_pop got id_vld=%h exp=1", id_vld); end
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (fq_empty !== 1'b1 || id_vld !== 1'b0) begin
         failures++; $display("FAIL frp_emptied got empty=%h id_vld=%h exp empty=1 id_vld=0", fq_empty, id_vld);
      end
      checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h4000) begin
         failures++; $display("FAIL frp_redirect_req got vld=%h addr=%h exp vld=1 addr=00004000", ic_req_vld, ic_req_addr);
      end
      n = 0;
      while (id_vld !== 1'b1 && n < 8) begin
         step();
         @(negedge clk);
         n++;
      end
      checks++; if (n != 2 || id_pc !== 32'h4000 || id_inst !== ~32'h4000) begin
         failures++; $display("FAIL frp_first_entry got wait=%0d pc=%h inst=%h exp wait=2 pc=00004000 inst=%h", n, id_pc, id_inst, ~32'h4000);
      end
   endtask

   // Access fault on 0x108 is tagged and fetch carries on.
   task automatic test_access_fault();
      int          k;
      logic [31:0] exp_pc;
      logic [1:0]  exp_err;
      hold_reset();
      lat      = 1;
      id_rdy   = 1'b1;
      err_addr = 32'h108;
      rst_n    = 1'b1;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         @(negedge clk);
         if (id_vld === 1'b1 && k < 5) begin
            exp_pc  = 32'h100 + 32'(4 * k);
            exp_err = (k == 2) ? 2'b01 : 2'b00;
            checks++; if (id_pc !== exp_pc || id_err !== exp_err) begin
               failures++; $display("FAIL fault_entry k=%0d got pc=%h err=%b exp pc=%h err=%b", k, id_pc, id_err, exp_pc, exp_err);
            end
            k++;
         end
      end
      checks++; if (k != 5) begin failures++; $display("FAIL fault_count got=%0d exp=5", k); end
      err_addr = 32'hFFFF_FFFF;
   endtask

`ifdef PANXI_IF_MISALIGN_CHK_EN
   // Misaligned redirect halts fetch and queues one err=10 entry.
   task automatic test_flush_misalign();
      hold_reset();
      lat    = 1;
      id_rdy = 1'b1;
      rst_n  = 1'b1;
      step();
      step();
      step();
      flush    = 1'b1;
      flush_pc = 32'h2002;
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b0 || id_vld !== 1'b0) begin
         failures++; $display("FAIL mis_halt got req_vld=%h id_vld=%h exp 0 0", ic_req_vld, id_vld);
      end
      step();
      @(negedge clk);
      checks++; if (id_vld !== 1'b1 || id_pc !== 32'h2002 || id_inst !== 32'h0 || id_err !== 2'b10) begin
         failures++; $display("FAIL mis_entry got vld=%h pc=%h inst=%h err=%b exp vld=1 pc=00002002 inst=0 err=10", id_vld, id_pc, id_inst, id_err);
      end
      step();
      @(negedge clk);
      checks++; if (id_vld !== 1'b0 || ic_req_vld !== 1'b0) begin
         failures++; $display("FAIL mis_single got id_vld=%h req_vld=%h exp 0 0", id_vld, ic_req_vld);
      end
      step();
      flush    = 1'b1;
      flush_pc = 32'h3000;
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h3000) begin
         failures++; $display("FAIL mis_resume got vld=%h addr=%h exp vld=1 addr=00003000", ic_req_vld, ic_req_addr);
      end
   endtask
`else
   // Without the check, low target bits are dropped and fetch proceeds.
   task automatic test_flush_unaligned();
      int n;
      hold_reset();
      lat    = 1;
      id_rdy = 1'b1;
      rst_n  = 1'b1;
      step();
      step();
      step();
      flush    = 1'b1;
      flush_pc = 32'h5002;
      step();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (ic_req_vld !== 1'b1 || ic_req_addr !== 32'h5000) begin
         failures++; $display("FAIL unal_req got vld=%h addr=%h exp vld=1 addr=00005000", ic_req_vld, ic_req_addr);
      end
      n = 0;
      while (id_vld !== 1'b1 && n < 8) begin
         step();
         @(negedge clk);
         n++;
      end
      checks++; if (id_pc !== 32'h5000 || id_inst !== ~32'h5000 || id_err !== 2'b00) begin
         failures++; $display("FAIL unal_entry got pc=%h inst=%h err=%b exp pc=00005000 inst=%h err=00", id_pc, id_inst, id_err, ~32'h5000);
      end
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      flush_pc   = '0;
      id_rdy     = 1'b0;
      ic_req_rdy = 1'b1;
      ic_rsp_vld = 1'b0;
      ic_rsp_data = '0;
      ic_rsp_err = 1'b0;
      test_reset();
      test_req_hold();
      test_stream();
      test_backpressure();
      test_flush_inflight();
      test_flush_rsp_pop();
      test_access_fault();
`ifdef PANXI_IF_MISALIGN_CHK_EN
      test_flush_misalign();
`else
      test_flush_unaligned();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
